// File: rtl/sa_tile_controller_if.sv
// Signal bundle between the tile sequencer and its host, operand/output SRAM banks and datapath.
// slave = sequencer side, master = environment side.
interface sa_tile_controller_if #(
  parameter int unsigned NUM_ROW = 8,
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned ADDR_W  = 10
);
  logic               i_start;
  logic               i_abort;
  logic [ADDR_W-1:0]  i_k_len;
  logic [ADDR_W-1:0]  i_top_base;
  logic [ADDR_W-1:0]  i_left_base;
  logic [ADDR_W-1:0]  i_out_base;
  logic               i_top_wr_en;
  logic [ADDR_W-1:0]  i_top_wr_addr;
  logic               i_left_wr_en;
  logic [ADDR_W-1:0]  i_left_wr_addr;
  logic               o_top_en;
  logic               o_top_we;
  logic [ADDR_W-1:0]  o_top_addr;
  logic               o_left_en;
  logic               o_left_we;
  logic [ADDR_W-1:0]  o_left_addr;
  logic [NUM_COL-1:0] o_valid_top;
  logic [NUM_ROW-1:0] o_valid_left;
  logic               o_clear_acc;
  logic               o_drain;
  logic [NUM_COL-1:0] i_sa_valid_down;
  logic [NUM_COL-1:0] o_out_we;
  logic [ADDR_W-1:0]  o_out_addr;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_abort, i_k_len, i_top_base, i_left_base, i_out_base,
           i_top_wr_en, i_top_wr_addr, i_left_wr_en, i_left_wr_addr, i_sa_valid_down,
    input  o_top_en, o_top_we, o_top_addr, o_left_en, o_left_we, o_left_addr,
           o_valid_top, o_valid_left, o_clear_acc, o_drain, o_out_we, o_out_addr,
           o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_k_len, i_top_base, i_left_base, i_out_base,
           i_top_wr_en, i_top_wr_addr, i_left_wr_en, i_left_wr_addr, i_sa_valid_down,
    output o_top_en, o_top_we, o_top_addr, o_left_en, o_left_we, o_left_addr,
           o_valid_top, o_valid_left, o_clear_acc, o_drain, o_out_we, o_out_addr,
           o_busy, o_done
  );
endinterface

// File: rtl/sa_tile_controller.sv
// Sequencer for one output-stationary systolic tile: clear, stream K operand rows with
// skewed valids, flush the wavefront, drain NUM_ROW result rows, pulse done.
module sa_tile_controller #(
  parameter int unsigned NUM_ROW = 8,
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter bit          SKEW_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  sa_tile_controller_if.slave bus
);
  localparam int unsigned DEPTH     = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL;
  localparam int unsigned FLUSH_LEN = NUM_ROW + NUM_COL + 1;
  localparam int unsigned FL_W      = $clog2(FLUSH_LEN);
  localparam int unsigned BEAT_W    = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   k_q;
  logic [ADDR_W-1:0]   top_base_q;
  logic [ADDR_W-1:0]   left_base_q;
  logic [ADDR_W-1:0]   out_base_q;
  logic [ADDR_W-1:0]   cnt;
  logic [FL_W-1:0]     flush_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [DEPTH-1:0]    vpipe;
  logic                rd_q;
  logic                clear_q;
  logic                drain_q;
  logic                busy_q;
  logic                done_q;
  logic                is_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_q         <= '0;
      top_base_q  <= '0;
      left_base_q <= '0;
      out_base_q  <= '0;
      cnt         <= '0;
      flush_cnt   <= '0;
      beat        <= '0;
      vpipe       <= '0;
      rd_q        <= 1'b0;
      clear_q     <= 1'b0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.i_abort) begin
      state     <= IDLE;
      cnt       <= '0;
      flush_cnt <= '0;
      beat      <= '0;
      vpipe     <= '0;
      rd_q      <= 1'b0;
      clear_q   <= 1'b0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Read-issue history; bit j is rd delayed j+1 cycles, keeps shifting through FLUSH.
      vpipe   <= DEPTH'({vpipe, rd_q});
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            k_q         <= bus.i_k_len;
            top_base_q  <= bus.i_top_base;
            left_base_q <= bus.i_left_base;
            out_base_q  <= bus.i_out_base;
            state       <= CLEAR;
            clear_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= '0;
          if (k_q != '0) begin
            state <= STREAM;
            rd_q  <= 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        STREAM: begin
          if (cnt == k_q - ADDR_W'(1)) begin
            state     <= FLUSH;
            rd_q      <= 1'b0;
            flush_cnt <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
            state   <= DRAIN;
            drain_q <= 1'b1;
            beat    <= '0;
          end else begin
            flush_cnt <= flush_cnt + FL_W'(1);
          end
        end
        DRAIN: begin
          if (|bus.i_sa_valid_down) begin
            if (beat == BEAT_W'(NUM_ROW - 1)) begin
              state   <= DONE;
              drain_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign is_idle = (state == IDLE);

  // Host writes pass straight through only while idle.
  assign bus.o_top_en    = is_idle ? bus.i_top_wr_en  : rd_q;
  assign bus.o_top_we    = is_idle & bus.i_top_wr_en;
  assign bus.o_top_addr  = is_idle ? bus.i_top_wr_addr  : (rd_q ? top_base_q + cnt  : '0);
  assign bus.o_left_en   = is_idle ? bus.i_left_wr_en : rd_q;
  assign bus.o_left_we   = is_idle & bus.i_left_wr_en;
  assign bus.o_left_addr = is_idle ? bus.i_left_wr_addr : (rd_q ? left_base_q + cnt : '0);

  assign bus.o_clear_acc = clear_q;
  assign bus.o_drain     = drain_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_out_we    = (drain_q && !bus.i_abort) ? bus.i_sa_valid_down : '0;
  assign bus.o_out_addr  = drain_q ? out_base_q + ADDR_W'(beat) : '0;

  always_comb begin
    bus.o_valid_top  = '0;
    bus.o_valid_left = '0;
    for (int unsigned c = 0; c < NUM_COL; c++)
      bus.o_valid_top[c] = SKEW_EN ? vpipe[c] : vpipe[0];
    for (int unsigned r = 0; r < NUM_ROW; r++)
      bus.o_valid_left[r] = SKEW_EN ? vpipe[r] : vpipe[0];
  end
endmodule

// File: doc/sa_tile_controller.md
# sa_tile_controller

Parametrised sequencer for one output-stationary systolic-array tile. It sits between the top/left operand SRAM banks, the `systolic_array_datapath`, and the output SRAM bank. On a start pulse it clears the PE accumulators, streams `K` operand rows with per-row/column skewed valids, waits for the wavefront to flush, then drains `NUM_ROW` result rows into the output bank and pulses done. While idle, it passes host write traffic through to the operand banks.

## Interface
- `NUM_ROW`, 8, PE rows / left valid lanes
- `NUM_COL`, 8, PE columns / top valid lanes
- `ADDR_W`, 10, SRAM address width; also the width of `K`
- `SKEW_EN`, 1, 1 = lane `i` valid delayed `i` extra cycles; 0 = all lanes aligned
- `clk` in 1 clock
- `rst_n` in 1 reset, asynchronous, active-low
- `i_start` in 1 start pulse; honoured only in IDLE
- `i_abort` in 1 synchronous abort; any state returns to IDLE
- `i_k_len` in ADDR_W reduction length K, sampled at start
- `i_top_base`, `i_left_base`, `i_out_base` in ADDR_W base addresses, sampled at start
- `i_top_wr_en`, `i_top_wr_addr` in 1/ADDR_W host write to top bank (IDLE only)
- `i_left_wr_en`, `i_left_wr_addr` in 1/ADDR_W host write to left bank (IDLE only)
- `o_top_en`, `o_top_we`, `o_top_addr` out 1/1/ADDR_W top bank port
- `o_left_en`, `o_left_we`, `o_left_addr` out 1/1/ADDR_W left bank port
- `o_valid_top` out NUM_COL column operand valids to datapath
- `o_valid_left` out NUM_ROW row operand valids to datapath
- `o_clear_acc` out 1 accumulator clear to all PEs
- `o_drain` out 1 datapath shift-out request
- `i_sa_valid_down` in NUM_COL per-column result valid from datapath
- `o_out_we` out NUM_COL per-column output bank write enable
- `o_out_addr` out ADDR_W output bank address
- `o_busy` out 1 high in every state except IDLE
- `o_done` out 1 one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE.
- IDLE:
  - `o_top_en=o_top_we=i_top_wr_en`, `o_top_addr=i_top_wr_addr`; left bank likewise.
  - `i_start` latches K and the bases, then moves to CLEAR. Start in any other state is ignored.
- CLEAR: one cycle with `o_clear_acc=1`. Then STREAM if K≠0, else DONE (no reads, no drain).
- STREAM: exactly K cycles with `o_top_en=o_left_en=1`, `we=0`.
  - Address = base + k for k=0..K-1, computed modulo 2^ADDR_W (wraps).
- FLUSH: fixed NUM_ROW+NUM_COL+1 cycles with no reads; lets the last operands reach PE(NUM_ROW-1,NUM_COL-1).
- DRAIN:
  - `o_drain=1`.
  - `o_out_we = i_sa_valid_down` (combinational).
  - `o_out_addr = i_out_base + beat` (mod 2^ADDR_W).
  - `beat` increments on each cycle with `|i_sa_valid_down`; exit to DONE after NUM_ROW beats.
  - No timeout: DRAIN waits indefinitely for beats.
- DONE: `o_done=1` for one cycle, then IDLE.
- Valid generation: internal read-issue flag `rd` is delayed 1 cycle for SRAM read latency.
  - SKEW_EN=1: `o_valid_top[c]` = `rd` delayed 1+c cycles; `o_valid_left[r]` = `rd` delayed 1+r cycles.
  - SKEW_EN=0: all lanes use the 1-cycle delay.
  - Skew pipes keep shifting through FLUSH, so trailing valids still emerge.
- Abort: IDLE next cycle; skew pipes cleared; no `o_done`; `o_out_we` forced 0 from the abort cycle onward.
- Abort and start in the same cycle: abort wins.

## Timing
- Reset values: all enables, valids, `o_clear_acc`, `o_drain`, `o_busy`, `o_done` = 0; addresses = 0; state IDLE. IDLE passthrough outputs follow their inputs, so they show 0 under reset only if the inputs are 0.
- Start sampled at cycle 0:
  - CLEAR at cycle 1.
  - STREAM at cycles 2..K+1.
  - `o_valid_top[c]` high at cycles 3+c..K+2+c (SKEW_EN=1).
  - FLUSH at cycles K+2..K+NUM_ROW+NUM_COL+2.
  - DRAIN from cycle K+NUM_ROW+NUM_COL+3.
- `o_done` asserts the cycle after the NUM_ROW-th beat is observed.
- `o_busy` is high from cycle 1 through the DONE cycle inclusive.
- Reset mid-operation: immediate return to IDLE with reset values; output bank untouched afterwards.

## Test plan
- Defaults, host writes in IDLE (`i_top_wr_en=1`, addr 5) -> `o_top_we=1`, `o_top_addr=5` same cycle; `i_start` not yet pulsed, so `o_busy=0`.
- K=4, top_base=10, left_base=20, out_base=100; `i_sa_valid_down=8'hFF` during drain -> top addrs 10..13 at cycles 2..5; `o_valid_top[7]` high cycles 10..13; out addrs 100..107; `o_done` exactly once.
- SKEW_EN=0, K=3 -> all 8 `o_valid_left` bits high together at cycles 3..5.
- top_base=1022, K=4, ADDR_W=10 -> `o_top_addr` sequence 1022, 1023, 0, 1.
- K=0 -> CLEAR, then DONE; `o_done` at cycle 2; no `o_top_en`, no `o_drain`.
- Abort in DRAIN after 3 beats -> IDLE next cycle, `o_out_we=0` thereafter, no `o_done`. Second `i_start` while busy -> ignored; beat count and addresses unchanged.
